// File: rtl/sram_wb_slave_if.sv
// Classic Wishbone B3 bus bundle: 32-bit data, byte address, 4-bit byte select.
// The slave modport is what sram_wb_slave exposes; the master modport is for whoever drives it.
interface wishbone_b3;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_m2s;
  logic [31:0] dat_s2m;
  logic        ack;
  logic        err;
  logic        rty;
  logic [2:0]  cti;
  logic [1:0]  bte;

  modport master (
    output cyc, stb, we, adr, sel, dat_m2s, cti, bte,
    input  dat_s2m, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_m2s, cti, bte,
    output dat_s2m, ack, err, rty
  );
endinterface

// File: rtl/sram_wb_slave.sv
// Wishbone B3 slave bridging 32-bit words onto a 16-bit asynchronous framebuffer SRAM.
// Optional feature: define SRAM_WB_SLAVE_RANGE_CHECK_EN to answer out-of-window requests with err.
module sram_wb_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
  parameter logic [31:0] SIZE_BYTES  = 32'h0020_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  wishbone_b3.slave   bus,
  output logic [19:0] sram_addr,
  inout  wire  [15:0] sram_dq,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [2:0] {IDLE, LO, HI, ACK, ERR} state_t;

  typedef struct packed {
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic        ub_n;
    logic        lb_n;
    logic [19:0] addr;
    logic        dq_oe;
    logic [15:0] dq_out;
  } sram_drive_t;

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

  localparam sram_drive_t DRV_RESET = '{
    ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, ub_n: 1'b1, lb_n: 1'b1,
    addr: 20'h0, dq_oe: 1'b0, dq_out: 16'h0
  };

  state_t      state;
  logic [2:0]  wait_cnt;
  logic        ack_q;
  logic [31:0] rd_q;
  sram_drive_t drv;

  // Request fields held for the whole transfer; the low half is consumed on IDLE exit.
  logic [18:0] word_q;
  logic        we_q;
  logic [1:0]  hi_sel_q;
  logic [15:0] hi_dat_q;

`ifdef SRAM_WB_SLAVE_RANGE_CHECK_EN
  localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + {1'b0, SIZE_BYTES};

  logic err_q;
  logic in_window;

  assign in_window = (bus.adr >= BASE_ADDR) && ({1'b0, bus.adr} < WIN_END);
`endif

  // Strobes for one half-word phase. The last phase cycle releases we_n for data hold,
  // so with no wait cycles the single phase cycle never pulses we_n.
  function automatic sram_drive_t phase_drive(
    input logic [18:0] word,
    input logic        half,
    input logic        wr,
    input logic [1:0]  sel2,
    input logic [15:0] data
  );
    sram_drive_t d;
    d.ce_n   = 1'b0;
    d.oe_n   = wr;
    d.we_n   = !(wr && (WAIT_CYCLES != 0));
    d.ub_n   = !sel2[1];
    d.lb_n   = !sel2[0];
    d.addr   = {word, half};
    d.dq_oe  = wr;
    d.dq_out = data;
    return d;
  endfunction

  function automatic sram_drive_t idle_drive(input sram_drive_t cur);
    sram_drive_t d;
    d       = cur;
    d.ce_n  = 1'b1;
    d.oe_n  = 1'b1;
    d.we_n  = 1'b1;
    d.ub_n  = 1'b1;
    d.lb_n  = 1'b1;
    d.dq_oe = 1'b0;
    return d;
  endfunction

  // NOTE: every register in this block is assigned with <= so all updates land together
  // at the clock edge; a blocking = here would let later lines see half-updated state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
      ack_q    <= 1'b0;
      rd_q     <= 32'h0;
      drv      <= DRV_RESET;
      word_q   <= 19'h0;
      we_q     <= 1'b0;
      hi_sel_q <= 2'b00;
      hi_dat_q <= 16'h0;
`ifdef SRAM_WB_SLAVE_RANGE_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cyc && bus.stb) begin
            word_q   <= bus.adr[20:2];
            we_q     <= bus.we;
            hi_sel_q <= bus.sel[3:2];
            hi_dat_q <= bus.dat_m2s[31:16];
`ifdef SRAM_WB_SLAVE_RANGE_CHECK_EN
            if (!in_window) begin
              state <= ERR;
              err_q <= 1'b1;
            end else
`endif
            if (|bus.sel[1:0]) begin
              state    <= LO;
              wait_cnt <= WAIT_LOAD;
              drv      <= phase_drive(bus.adr[20:2], 1'b0, bus.we, bus.sel[1:0],
                                      bus.dat_m2s[15:0]);
            end else if (|bus.sel[3:2]) begin
              state    <= HI;
              wait_cnt <= WAIT_LOAD;
              drv      <= phase_drive(bus.adr[20:2], 1'b1, bus.we, bus.sel[3:2],
                                      bus.dat_m2s[31:16]);
            end else begin
              state <= ACK;
              ack_q <= 1'b1;
            end
          end
        end

        LO: begin
          if (!bus.cyc) begin
            state <= IDLE;
            drv   <= idle_drive(drv);
          end else if (wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
            if (wait_cnt == 3'd1) drv.we_n <= 1'b1;
          end else begin
            if (!we_q) rd_q[15:0] <= sram_dq;
            if (|hi_sel_q) begin
              state    <= HI;
              wait_cnt <= WAIT_LOAD;
              drv      <= phase_drive(word_q, 1'b1, we_q, hi_sel_q, hi_dat_q);
            end else begin
              state <= ACK;
              ack_q <= 1'b1;
              drv   <= idle_drive(drv);
            end
          end
        end

        HI: begin
          if (!bus.cyc) begin
            state <= IDLE;
            drv   <= idle_drive(drv);
          end else if (wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
            if (wait_cnt == 3'd1) drv.we_n <= 1'b1;
          end else begin
            if (!we_q) rd_q[31:16] <= sram_dq;
            state <= ACK;
            ack_q <= 1'b1;
            drv   <= idle_drive(drv);
          end
        end

        ACK: state <= IDLE;

        ERR: begin
          state <= IDLE;
`ifdef SRAM_WB_SLAVE_RANGE_CHECK_EN
          err_q <= 1'b0;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign sram_addr = drv.addr;
  assign sram_ce_n = drv.ce_n;
  assign sram_oe_n = drv.oe_n;
  assign sram_we_n = drv.we_n;
  assign sram_ub_n = drv.ub_n;
  assign sram_lb_n = drv.lb_n;
  assign sram_dq   = drv.dq_oe ? drv.dq_out : 16'hzzzz;

  assign bus.ack     = ack_q;
  assign bus.dat_s2m = rd_q;
  assign bus.rty     = 1'b0;
`ifdef SRAM_WB_SLAVE_RANGE_CHECK_EN
  assign bus.err     = err_q;
`else
  assign bus.err     = 1'b0;
`endif

  // Burst hints and out-of-window address bits have no effect on a classic-cycle slave.
  wire unused_ok = &{1'b0, bus.cti, bus.bte, bus.adr[31:21], bus.adr[1:0],
                     BASE_ADDR[0], SIZE_BYTES[0]};

endmodule

// File: tb/tb_sram_wb_slave.sv
// Directed bench for sram_wb_slave: behavioural SRAM, read scoreboard, immediate-assertion checks.
module tb_sram_wb_slave;
  localparam int          W        = 2;
  localparam int          LAT_FULL = 2 * W + 3;
  localparam int          LAT_HALF = W + 2;
  localparam int          PERIOD   = 2 * W + 4;
  localparam logic [31:0] ROW1     = 32'h0200_0C80;

  logic        clk = 1'b0;
  logic        rst;
  wire  [15:0] sram_dq;
  logic [19:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  wishbone_b3 wb ();

  sram_wb_slave #(
    .BASE_ADDR  (32'h0200_0000),
    .SIZE_BYTES (32'h0020_0000),
    .WAIT_CYCLES(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (wb),
    .sram_addr(sram_addr),
    .sram_dq  (sram_dq),
    .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM model: drives on read, captures enabled byte lanes while we_n is low.
  bit [15:0] mem [0:(1<<20)-1];

  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'hzzzz;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_dq[7:0];
      if (!sram_ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  int   lat, ce_cyc, we_cyc, ub_cyc, lb_cyc;
  bit   got_ack, got_err;
  logic [1:0] resp_after;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [15:0] k;
    k = i[15:0];
    return {k ^ 16'h5A00, ~k};
  endfunction

  task automatic bus_idle();
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.adr = 32'h0;
    wb.sel = 4'h0; wb.dat_m2s = 32'h0; wb.cti = 3'b000; wb.bte = 2'b00;
  endtask

  function automatic logic [31:0] strobes();
    return 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
  endfunction

  // One classic transfer, started on a negedge with the slave in IDLE.
  task automatic xfer(input logic wr, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input logic [31:0] exp_rd, input bit perturb);
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = wr; wb.adr = adr; wb.sel = sel;
    wb.dat_m2s = dat; wb.cti = 3'b010; wb.bte = 2'b01;
    if (!wr) exp_q.push_back(exp_rd);
    lat = 0; ce_cyc = 0; we_cyc = 0; ub_cyc = 0; lb_cyc = 0;
    got_ack = 1'b0; got_err = 1'b0;
    while (!got_ack && !got_err && lat < 50) begin
      @(negedge clk);
      lat++;
      if (!sram_ce_n) ce_cyc++;
      if (!sram_ce_n && !sram_we_n) we_cyc++;
      if (!sram_ce_n && !sram_ub_n) ub_cyc++;
      if (!sram_ce_n && !sram_lb_n) lb_cyc++;
      got_ack = wb.ack;
      got_err = wb.err;
      if (perturb && lat == 2) begin
        wb.adr = adr ^ 32'h0000_0040; wb.dat_m2s = ~dat; wb.sel = 4'h0; wb.we = ~wr;
      end
    end
    if (!wr) begin
      if (got_ack) check("read_data", wb.dat_s2m, exp_q.pop_front());
      else if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    wb.cyc = 1'b0; wb.stb = 1'b0;
    @(negedge clk);
    resp_after = {wb.ack, wb.err};
  endtask

  // Master holds stb and advances the address on every ack, as a row fetch would.
  task automatic stream(input logic wr, input int n);
    int acks, cycles, last, bad_gap, err_seen;
    acks = 0; cycles = 0; last = 0; bad_gap = 0; err_seen = 0;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = wr; wb.sel = 4'hF;
    wb.adr = ROW1; wb.dat_m2s = pat(0);
    if (!wr) exp_q.push_back(pat(0));
    while (acks < n && cycles < n * PERIOD + 50) begin
      @(negedge clk);
      cycles++;
      if (wb.err) err_seen++;
      if (wb.ack) begin
        if (!wr) check("stream_rd", wb.dat_s2m, exp_q.pop_front());
        if (acks == 0) begin
          if (cycles != LAT_FULL) bad_gap++;
        end else if (cycles - last != PERIOD) bad_gap++;
        last = cycles;
        acks++;
        if (acks < n) begin
          wb.adr     = ROW1 + 32'(acks) * 32'd4;
          wb.dat_m2s = pat(acks);
          if (!wr) exp_q.push_back(pat(acks));
        end
      end
    end
    bus_idle();
    @(negedge clk);
    check(wr ? "stream_wr_acks" : "stream_rd_acks", 32'(acks), 32'(n));
    check(wr ? "stream_wr_timing" : "stream_rd_timing", 32'(bad_gap), 32'd0);
    check(wr ? "stream_wr_err" : "stream_rd_err", 32'(err_seen), 32'd0);
  endtask

  initial begin
    int ack_seen;
    rst = 1'b1;
    bus_idle();
    repeat (3) @(negedge clk);

    check("rst_ack", 32'(wb.ack), 32'd0);
    check("rst_err", 32'(wb.err), 32'd0);
    check("rst_rty", 32'(wb.rty), 32'd0);
    check("rst_dat", wb.dat_s2m, 32'h0);
    check("rst_strobes", strobes(), 32'h1F);
    check("rst_addr", 32'(sram_addr), 32'h0);

    rst = 1'b0;
    @(negedge clk);

    // Full-word write then read back.
    xfer(1'b1, 32'h0200_0010, 4'hF, 32'hA1B2_C3D4, 32'h0, 1'b0);
    check("wr_full_lat", 32'(lat), 32'(LAT_FULL));
    check("wr_full_ce", 32'(ce_cyc), 32'(2 * (W + 1)));
    check("wr_full_we", 32'(we_cyc), 32'(2 * W));
    check("wr_full_ub", 32'(ub_cyc), 32'(2 * (W + 1)));
    check("wr_full_hw8", 32'(mem[8]), 32'h0000_C3D4);
    check("wr_full_hw9", 32'(mem[9]), 32'h0000_A1B2);
    check("wr_full_ack_width", 32'(resp_after), 32'd0);

    xfer(1'b0, 32'h0200_0010, 4'hF, 32'h0, 32'hA1B2_C3D4, 1'b0);
    check("rd_full_lat", 32'(lat), 32'(LAT_FULL));
    check("rd_full_ce", 32'(ce_cyc), 32'(2 * (W + 1)));
    check("rd_full_we", 32'(we_cyc), 32'd0);
    check("rd_full_ack_width", 32'(resp_after), 32'd0);

    // Half-word and byte selects: skipped phases cost nothing.
    xfer(1'b1, 32'h0200_0010, 4'b0011, 32'hFFFF_1234, 32'h0, 1'b0);
    check("wr_lo_lat", 32'(lat), 32'(LAT_HALF));
    check("wr_lo_ce", 32'(ce_cyc), 32'(W + 1));
    check("wr_lo_hw8", 32'(mem[8]), 32'h0000_1234);
    check("wr_lo_hw9", 32'(mem[9]), 32'h0000_A1B2);

    xfer(1'b1, 32'h0200_0010, 4'b1100, 32'h5678_0000, 32'h0, 1'b0);
    check("wr_hi_lat", 32'(lat), 32'(LAT_HALF));
    check("wr_hi_hw9", 32'(mem[9]), 32'h0000_5678);

    xfer(1'b1, 32'h0200_0010, 4'b0100, 32'h00AB_0000, 32'h0, 1'b0);
    check("wr_byte_lat", 32'(lat), 32'(LAT_HALF));
    check("wr_byte_ub", 32'(ub_cyc), 32'd0);
    check("wr_byte_lb", 32'(lb_cyc), 32'(W + 1));
    check("wr_byte_hw9", 32'(mem[9]), 32'h0000_56AB);

    xfer(1'b1, 32'h0200_0010, 4'b0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
    check("wr_none_lat", 32'(lat), 32'd1);
    check("wr_none_ce", 32'(ce_cyc), 32'd0);
    check("wr_none_hw8", 32'(mem[8]), 32'h0000_1234);

    xfer(1'b0, 32'h0200_0010, 4'hF, 32'h0, 32'h56AB_1234, 1'b0);
    check("rd_mix_lat", 32'(lat), 32'(LAT_FULL));

    // Bus changes mid-transfer are ignored.
    xfer(1'b1, 32'h0200_0020, 4'hF, 32'h1111_2222, 32'h0, 1'b1);
    check("latch_lat", 32'(lat), 32'(LAT_FULL));
    check("latch_hw16", 32'(mem[16]), 32'h0000_2222);
    check("latch_hw17", 32'(mem[17]), 32'h0000_1111);
    check("latch_hw48", 32'(mem[48]), 32'h0);

    // Master abandons a read in LO.
    ack_seen = 0;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = 32'h0200_0010; wb.sel = 4'hF;
    repeat (2) begin
      @(negedge clk);
      if (wb.ack) ack_seen++;
    end
    check("abort_active_ce", 32'(sram_ce_n), 32'd0);
    bus_idle();
    @(negedge clk);
    check("abort_strobes", strobes(), 32'h1F);
    repeat (10) begin
      @(negedge clk);
      if (wb.ack) ack_seen++;
    end
    check("abort_no_ack", 32'(ack_seen), 32'd0);

    xfer(1'b0, 32'h0200_0010, 4'hF, 32'h0, 32'h56AB_1234, 1'b0);
    check("after_abort_lat", 32'(lat), 32'(LAT_FULL));

    // Reset in the middle of a write.
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b1; wb.adr = 32'h0200_0080;
    wb.sel = 4'hF; wb.dat_m2s = 32'h9999_8888;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_abort_strobes", strobes(), 32'h1F);
    check("rst_abort_ack", 32'(wb.ack), 32'd0);
    check("rst_abort_dat", wb.dat_s2m, 32'h0);
    bus_idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Address outside the window.
    xfer(1'b1, 32'h0200_0000, 4'hF, 32'hCAFE_0BEE, 32'h0, 1'b0);
    xfer(1'b0, 32'h0300_0000, 4'hF, 32'h0, 32'hCAFE_0BEE, 1'b0);
`ifdef SRAM_WB_SLAVE_RANGE_CHECK_EN
    check("range_err", 32'(got_err), 32'd1);
    check("range_no_ack", 32'(got_ack), 32'd0);
    check("range_lat", 32'(lat), 32'd1);
    check("range_ce", 32'(ce_cyc), 32'd0);
    check("range_err_width", 32'(resp_after), 32'd0);
`else
    check("alias_ack", 32'(got_ack), 32'd1);
    check("alias_lat", 32'(lat), 32'(LAT_FULL));
    check("alias_err", 32'(got_err), 32'd0);
`endif

    // One framebuffer row: 800 streamed writes, then 800 streamed reads.
    stream(1'b1, 800);
    stream(1'b0, 800);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
